// File: rtl/jtpang_busarb.sv
// rtl/jtpang_busarb.sv - Z80 bus arbiter granting the bus to object DMA on idle-bus cycles
module jtpang_busarb #(
  parameter logic [15:0] TMAX   = 16'd4096,
  parameter logic [3:0]  MINGAP = 4'd2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_cen,
  input  logic busrq,
  input  logic mreq_n,
  input  logic iorq_n,
  output logic busak_n,
  output logic cpu_hold,
  output logic dma_busy,
  output logic timeout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    GRANT = 3'd2,
    REL   = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t      state, state_d;
  logic [15:0] tick_cnt, tick_cnt_d;
  logic [3:0]  gap_cnt, gap_cnt_d;
  logic        timeout_d;
  logic [1:0]  rst_sync;
  logic        run;
  logic        bus_idle;

  // The FSM only moves once reset release has crossed two flops.
  assign run      = rst_sync[1];
  assign bus_idle = mreq_n & iorq_n;

  // Reset deassertion synchroniser; assertion stays asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= 16'd0;
      gap_cnt  <= 4'd0;
      timeout  <= 1'b0;
      busak_n  <= 1'b1;
      cpu_hold <= 1'b0;
      dma_busy <= 1'b0;
    end else begin
      state    <= state_d;
      tick_cnt <= tick_cnt_d;
      gap_cnt  <= gap_cnt_d;
      timeout  <= timeout_d;
      busak_n  <= (state_d != GRANT);
      cpu_hold <= (state_d == GRANT) || (state_d == REL);
      dma_busy <= (state_d == WAIT) || (state_d == GRANT) || (state_d == REL);
    end
  end

  // Next-state and counter logic; a busrq drop wins over a timeout on the same edge.
  always_comb begin
    state_d    = state;
    tick_cnt_d = tick_cnt;
    gap_cnt_d  = gap_cnt;
    timeout_d  = timeout;
    if (run) begin
      case (state)
        IDLE: begin
          if (busrq) state_d = WAIT;
        end
        WAIT: begin
          if (!busrq) begin
            state_d = IDLE;
          end else if (cpu_cen && bus_idle) begin
            state_d    = GRANT;
            tick_cnt_d = 16'd0;
          end
        end
        GRANT: begin
          if (cpu_cen && (tick_cnt != 16'hFFFF)) tick_cnt_d = tick_cnt + 16'd1;
          if (!busrq) begin
            state_d = REL;
          end else if (cpu_cen && (tick_cnt == TMAX - 16'd1)) begin
            state_d   = REL;
            timeout_d = 1'b1;
          end
        end
        REL: begin
          state_d   = GAP;
          gap_cnt_d = 4'd0;
        end
        GAP: begin
          if (MINGAP == 4'd0) begin
            state_d = IDLE;
          end else if (cpu_cen) begin
            if (gap_cnt == MINGAP - 4'd1) state_d = IDLE;
            else gap_cnt_d = gap_cnt + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
